// File: rtl/push_button_debouncer.sv
// rtl/push_button_debouncer.sv - four-channel push-button synchroniser, debouncer and auto-repeat pulser
//
// Purpose: turns raw active-low button pins into one-clock active-high press
// pulses, with optional auto-repeat while a button stays held.
// Channel map: [0] Previous, [1] Next, [2] Okay, [3] Cancel.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       block enable; low clears every channel and holds oButton at 0
//   iButton  raw button pins, active-low, asynchronous to clk
//   oButton  registered one-cycle press/repeat pulses, active-high
module push_button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES      = 500000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000,
  parameter logic [3:0]  REPEAT_MASK          = 4'b0011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] iButton,
  output logic [3:0] oButton
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                     REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  // A release is accepted on its DEBOUNCE_CYCLES-th consecutive high sample.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // A press is accepted one sample after the counter has filled, giving a
  // pin-to-pulse latency of 2 (synchroniser) + DEBOUNCE_CYCLES edges.
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);
  // Repeat pulses fire on the edge the hold counter would reach its target.
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_REL,
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_t;

  // Two-flop synchroniser, resets to "released" and runs regardless of en.
  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 4'hF;
      r_sync <= 4'hF;
    end else begin
      r_meta <= iButton;
      r_sync <= r_meta;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    state_t            r_state;
    logic [DB_W-1:0]   r_rel_cnt;
    logic [DB_W-1:0]   r_prs_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_pulse;
    logic              w_sync;

    assign w_sync     = r_sync[g];
    assign oButton[g] = r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_WAIT_REL;
        r_rel_cnt  <= '0;
        r_prs_cnt  <= '0;
        r_hold_cnt <= '0;
        r_pulse    <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!en) begin
          // Forcing WAIT_REL means a button held across the en rise must be
          // released before it can produce a pulse.
          r_state    <= ST_WAIT_REL;
          r_rel_cnt  <= '0;
          r_prs_cnt  <= '0;
          r_hold_cnt <= '0;
        end else begin
          case (r_state)
            ST_WAIT_REL: begin
              if (w_sync) begin
                if (r_rel_cnt == DB_LAST) begin
                  r_state   <= ST_IDLE;
                  r_rel_cnt <= '0;
                end else begin
                  r_rel_cnt <= r_rel_cnt + 1'b1;
                end
              end else begin
                r_rel_cnt <= '0;
              end
            end

            ST_IDLE: begin
              if (!w_sync) begin
                if (r_prs_cnt == DB_FULL) begin
                  r_pulse    <= 1'b1;
                  r_state    <= ST_HELD;
                  r_prs_cnt  <= '0;
                  r_rel_cnt  <= '0;
                  r_hold_cnt <= '0;
                end else begin
                  r_prs_cnt <= r_prs_cnt + 1'b1;
                end
              end else begin
                r_prs_cnt <= '0;
              end
            end

            ST_HELD, ST_REPEAT: begin
              if (w_sync) begin
                // High samples do not advance the hold timer, so short release
                // glitches only stretch the repeat interval.
                if (r_rel_cnt == DB_LAST) begin
                  r_state    <= ST_IDLE;
                  r_rel_cnt  <= '0;
                  r_prs_cnt  <= '0;
                  r_hold_cnt <= '0;
                end else begin
                  r_rel_cnt <= r_rel_cnt + 1'b1;
                end
              end else begin
                r_rel_cnt <= '0;
                if (REPEAT_MASK[g]) begin
                  if (r_state == ST_HELD && r_hold_cnt == DELAY_LAST) begin
                    r_pulse    <= 1'b1;
                    r_hold_cnt <= '0;
                    r_state    <= ST_REPEAT;
                  end else if (r_state == ST_REPEAT && r_hold_cnt == PERIOD_LAST) begin
                    r_pulse    <= 1'b1;
                    r_hold_cnt <= '0;
                  end else begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                  end
                end
              end
            end

            default: r_state <= ST_WAIT_REL;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_push_button_debouncer.sv
// tb/tb_push_button_debouncer.sv - scoreboard bench for push_button_debouncer
module tb_push_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] iButton;
  logic [3:0] oButton;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         at_edge;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];

  push_button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_PERIOD_CYCLES(8),
    .REPEAT_MASK(4'b0011)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .iButton(iButton),
    .oButton(oButton)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen; at a negedge it names the
  // edge that produced the current output.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_pulse(input int at_edge, input logic [3:0] val);
    exp_t e;
    e.at_edge = at_edge;
    e.val     = val;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: oButton=%b expected=%b at edge %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: retires overdue expectations as misses, then compares every
  // non-zero output against the head of the queue.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at_edge < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse: oButton stayed 0000, expected %b at edge %0d", exp_q[0].val, exp_q[0].at_edge);
      void'(exp_q.pop_front());
    end
    if (oButton !== 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: oButton=%b at edge %0d, expected none", oButton, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.at_edge != cyc || e.val !== oButton) begin
          failures++;
          $display("FAIL pulse: oButton=%b at edge %0d, expected %b at edge %0d",
                   oButton, cyc, e.val, e.at_edge);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [6:0] pat;

    rst_n   = 1'b0;
    en      = 1'b1;
    iButton = 4'hF;
    @(negedge clk);
    check_now("reset_out_a", oButton, 4'b0000);
    @(negedge clk);
    check_now("reset_out_b", oButton, 4'b0000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Clean press on Okay: single pulse, no auto-repeat.
    iButton[2] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6, 4'b0100);
    repeat (40) @(negedge clk);
    iButton[2] = 1'b1;
    repeat (10) @(negedge clk);

    // Bounce on Previous, then a 1-cycle release glitch while held.
    pat = 7'b0000100;
    k = cyc + 1;
    expect_pulse(k + 9, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      iButton[0] = pat[i];
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    iButton[0] = 1'b1;
    @(negedge clk);
    iButton[0] = 1'b0;
    repeat (8) @(negedge clk);
    iButton[0] = 1'b1;
    repeat (10) @(negedge clk);

    // Auto-repeat on Next, short release, fresh press.
    iButton[1] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6,  4'b0010);
    expect_pulse(k + 26, 4'b0010);
    expect_pulse(k + 34, 4'b0010);
    expect_pulse(k + 42, 4'b0010);
    expect_pulse(k + 50, 4'b0010);
    expect_pulse(k + 58, 4'b0010);
    repeat (60) @(negedge clk);
    iButton[1] = 1'b1;
    repeat (4) @(negedge clk);
    iButton[1] = 1'b0;
    expect_pulse(k + 70, 4'b0010);
    repeat (10) @(negedge clk);
    iButton[1] = 1'b1;
    repeat (10) @(negedge clk);

    // Cancel held through en rise: ignored until released and pressed again.
    en = 1'b0;
    iButton[3] = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    iButton[3] = 1'b1;
    repeat (8) @(negedge clk);
    iButton[3] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6, 4'b1000);
    repeat (10) @(negedge clk);
    iButton[3] = 1'b1;
    repeat (10) @(negedge clk);

    // Drop en while Previous is repeating.
    iButton[0] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6,  4'b0001);
    expect_pulse(k + 26, 4'b0001);
    repeat (27) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_now("en_drop_out", oButton, 4'b0000);
    repeat (4) @(negedge clk);
    iButton[0] = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);

    // Simultaneous press on Previous and Next.
    iButton = 4'b1100;
    k = cyc + 1;
    expect_pulse(k + 6, 4'b0011);
    repeat (15) @(negedge clk);
    iButton = 4'hF;
    repeat (10) @(negedge clk);

    // Asynchronous reset while Next is repeating, button still held after.
    iButton[1] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6,  4'b0010);
    expect_pulse(k + 26, 4'b0010);
    expect_pulse(k + 34, 4'b0010);
    repeat (35) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_now("async_reset_out", oButton, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    iButton[1] = 1'b1;
    repeat (8) @(negedge clk);
    iButton[1] = 1'b0;
    k = cyc + 1;
    expect_pulse(k + 6, 4'b0010);
    repeat (10) @(negedge clk);
    iButton[1] = 1'b1;
    repeat (10) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations: remaining=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
